// File: rtl/prg_dma_loader_if.sv
// Bus bundle for the PRG DMA loader: byte-stream handshake on one side,
// C64 expansion-port DMA signals on the other, plus status flags.
interface prg_dma_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        phi2;
  logic        ba;
  logic        dma;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        rw;
  logic        busy;
  logic        done;
  logic        err;

  // Loader side: consumes the stream, drives the C64 bus
  modport master (
    input  s_data, s_valid, s_last, phi2, ba,
    output s_ready, dma, addr, dout, rw, busy, done, err
  );

  // Host / system side: supplies the stream and phi2/ba, observes the bus
  modport slave (
    output s_data, s_valid, s_last, phi2, ba,
    input  s_ready, dma, addr, dout, rw, busy, done, err
  );
endinterface

// File: rtl/prg_dma_loader.sv
// PRG DMA loader: takes a .PRG byte stream (load address LSB/MSB, then
// payload), holds the CPU off via DMA and writes each payload byte to
// consecutive C64 addresses, one write per phi2 high phase, gated by BA.
// Optionally patches BASIC's VARTAB pointer with the end address.
module prg_dma_loader #(
  parameter bit          PATCH_VARTAB = 1'b1,
  parameter logic [15:0] VARTAB_ADDR  = 16'h002D
) (
  input  logic              clk,
  input  logic              reset,
  prg_dma_loader_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_FETCH,
    S_ARM,
    S_WRITE,
    S_PTR_LO,
    S_PTR_HI,
    S_DONE
  } state_t;

  // What the write currently in S_WRITE is for; decides where to go on fall
  typedef enum logic [1:0] {
    WK_DATA,
    WK_PTR_LO,
    WK_PTR_HI
  } wkind_t;

  state_t      state_q, state_d;
  wkind_t      kind_q, kind_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        rw_q, rw_d;
  logic        dma_q, dma_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [7:0]  endhi_q, endhi_d;
  logic        phi2_q;

  logic        phi2_rise;
  logic        phi2_fall;
  logic        s_ready_c;
  logic        accept;
  logic [15:0] addr_inc;

  assign phi2_rise = bus.phi2 & ~phi2_q;
  assign phi2_fall = ~bus.phi2 & phi2_q;
  assign accept    = s_ready_c & bus.s_valid;
  // 16-bit wrap is intended: $FFFF + 1 -> $0000
  assign addr_inc  = addr_q + 16'd1;

  // State and datapath registers; reset drops DMA and releases the bus at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= WK_DATA;
      addr_q  <= 16'h0000;
      dout_q  <= 8'h00;
      rw_q    <= 1'b1;
      dma_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      endhi_q <= 8'h00;
      phi2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rw_q    <= rw_d;
      dma_q   <= dma_d;
      err_q   <= err_d;
      last_q  <= last_d;
      endhi_q <= endhi_d;
      phi2_q  <= bus.phi2;
    end
  end

  // Next-state and register-update logic for the load sequencer
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rw_d      = rw_q;
    dma_d     = dma_q;
    err_d     = err_q;
    last_d    = last_q;
    endhi_d   = endhi_q;
    s_ready_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.s_valid) begin
          state_d = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        s_ready_c = 1'b1;
        if (accept) begin
          if (bus.s_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d[7:0] = bus.s_data;
            state_d     = S_HDR_HI;
          end
        end
      end

      S_HDR_HI: begin
        s_ready_c = 1'b1;
        if (accept) begin
          if (bus.s_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d[15:8] = bus.s_data;
            state_d      = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        s_ready_c = 1'b1;
        if (accept) begin
          dout_d  = bus.s_data;
          last_d  = bus.s_last;
          dma_d   = 1'b1;
          state_d = S_ARM;
        end
      end

      // Start a write only on a phi2 rising edge the VIC is not stealing
      S_ARM: begin
        if (phi2_rise && bus.ba) begin
          rw_d    = 1'b0;
          kind_d  = WK_DATA;
          state_d = S_WRITE;
        end
      end

      S_PTR_LO: begin
        if (phi2_rise && bus.ba) begin
          rw_d    = 1'b0;
          kind_d  = WK_PTR_LO;
          state_d = S_WRITE;
        end
      end

      S_PTR_HI: begin
        if (phi2_rise && bus.ba) begin
          rw_d    = 1'b0;
          kind_d  = WK_PTR_HI;
          state_d = S_WRITE;
        end
      end

      // Hold addr/dout/rw through phi2 high; finish the cycle on its fall
      S_WRITE: begin
        if (phi2_fall) begin
          rw_d   = 1'b1;
          addr_d = addr_inc;
          unique case (kind_q)
            WK_DATA: begin
              if (!last_q) begin
                state_d = S_FETCH;
              end else if (PATCH_VARTAB) begin
                // addr_inc is the end address; stash its MSB for PTR_HI
                endhi_d = addr_inc[15:8];
                dout_d  = addr_inc[7:0];
                addr_d  = VARTAB_ADDR;
                state_d = S_PTR_LO;
              end else begin
                dma_d   = 1'b0;
                state_d = S_DONE;
              end
            end
            WK_PTR_LO: begin
              // addr_inc is VARTAB_ADDR + 1 here
              dout_d  = endhi_q;
              state_d = S_PTR_HI;
            end
            default: begin
              dma_d   = 1'b0;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        rw_d    = 1'b1;
        dma_d   = 1'b0;
      end
    endcase
  end

  assign bus.s_ready = s_ready_c;
  assign bus.dma     = dma_q;
  assign bus.addr    = addr_q;
  assign bus.dout    = dout_q;
  assign bus.rw      = rw_q;
  assign bus.err     = err_q;
  assign bus.done    = (state_q == S_DONE);
  assign bus.busy    = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_prg_dma_loader.sv
// Bench for prg_dma_loader: one instance without and one with the VARTAB
// patch, fed the same stream; every bus write is scored against a queue.
module tb_prg_dma_loader;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic       clk;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       phi2;
  logic       ba;

  int n_checks;
  int n_fail;
  int wr_cnt_a, wr_cnt_b;
  int done_a, done_b;
  int done_exp_a, done_exp_b;
  bit dma_seen_a, dma_seen_b;
  logic rw_prev_a, rw_prev_b;
  wr_t exp_a[$];
  wr_t exp_b[$];

  prg_dma_loader_if ifa ();
  prg_dma_loader_if ifb ();

  assign ifa.s_data  = s_data;
  assign ifa.s_valid = s_valid;
  assign ifa.s_last  = s_last;
  assign ifa.phi2    = phi2;
  assign ifa.ba      = ba;
  assign ifb.s_data  = s_data;
  assign ifb.s_valid = s_valid;
  assign ifb.s_last  = s_last;
  assign ifb.phi2    = phi2;
  assign ifb.ba      = ba;

  prg_dma_loader #(.PATCH_VARTAB(1'b0), .VARTAB_ADDR(16'h002D)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.master)
  );

  prg_dma_loader #(.PATCH_VARTAB(1'b1), .VARTAB_ADDR(16'h002D)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phi2: 4 clk low, 4 clk high, changing just after a clk edge
  initial begin
    phi2 = 1'b0;
    forever begin
      repeat (4) @(posedge clk);
      #1 phi2 = ~phi2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor for the unpatched instance
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (ifa.rw === 1'b0 && rw_prev_a === 1'b1) begin
        wr_cnt_a++;
        check("a_wr_in_phi2_high", phi2, 1);
        if (exp_a.size() == 0) begin
          check("a_wr_unexpected", exp_a.size(), 1);
        end else begin
          e = exp_a.pop_front();
          check("a_wr_addr", ifa.addr, e.a);
          check("a_wr_data", ifa.dout, e.d);
        end
      end
      if (ifa.done) done_a++;
      if (ifa.dma) dma_seen_a = 1'b1;
    end
    rw_prev_a = ifa.rw;
  end

  // Write monitor for the VARTAB-patching instance
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (ifb.rw === 1'b0 && rw_prev_b === 1'b1) begin
        wr_cnt_b++;
        check("b_wr_in_phi2_high", phi2, 1);
        if (exp_b.size() == 0) begin
          check("b_wr_unexpected", exp_b.size(), 1);
        end else begin
          e = exp_b.pop_front();
          check("b_wr_addr", ifb.addr, e.a);
          check("b_wr_data", ifb.dout, e.d);
        end
      end
      if (ifb.done) done_b++;
      if (ifb.dma) dma_seen_b = 1'b1;
    end
    rw_prev_b = ifb.rw;
  end

  task automatic push_a(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_b.push_back(e);
  endtask

  task automatic push_both(input logic [15:0] a, input logic [7:0] d);
    push_a(a, d);
    push_b(a, d);
  endtask

  // Present one byte and hold it until the loader takes it (bounded)
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (ifa.s_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("send_accept", ifa.s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait for both done pulses, then confirm the bus is released and scored
  task automatic finish_load(input string tag);
    int t;
    t = 0;
    while ((done_a < done_exp_a || done_b < done_exp_b) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_a"}, done_a, done_exp_a);
    check({tag, "_done_b"}, done_b, done_exp_b);
    check({tag, "_left_a"}, exp_a.size(), 0);
    check({tag, "_left_b"}, exp_b.size(), 0);
    check({tag, "_dma_a"}, ifa.dma, 0);
    check({tag, "_dma_b"}, ifb.dma, 0);
    check({tag, "_rw_b"}, ifb.rw, 1);
    check({tag, "_busy_b"}, ifb.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0a, w0b, t;
    n_checks = 0;
    n_fail = 0;
    wr_cnt_a = 0;
    wr_cnt_b = 0;
    done_a = 0;
    done_b = 0;
    done_exp_a = 0;
    done_exp_b = 0;
    dma_seen_a = 1'b0;
    dma_seen_b = 1'b0;
    reset   = 1'b1;
    s_data  = 8'h00;
    s_valid = 1'b0;
    s_last  = 1'b0;
    ba      = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dma", ifb.dma, 0);
    check("rst_rw", ifb.rw, 1);
    check("rst_addr", ifb.addr, 16'h0000);
    check("rst_dout", ifb.dout, 8'h00);
    check("rst_ready", ifb.s_ready, 0);
    check("rst_busy", ifb.busy, 0);
    check("rst_done", ifb.done, 0);
    check("rst_err", ifb.err, 0);
    check("rst_rw_a", ifa.rw, 1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic stream 01 08 A9 00
    push_both(16'h0801, 8'hA9);
    push_both(16'h0802, 8'h00);
    push_b(16'h002D, 8'h03);
    push_b(16'h002E, 8'h08);
    done_exp_a++;
    done_exp_b++;
    send_byte(8'h01, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'hA9, 1'b0);
    send_byte(8'h00, 1'b1);
    finish_load("basic");
    check("basic_wr_a", wr_cnt_a, 2);
    check("basic_wr_b", wr_cnt_b, 4);

    // BA held low for three phi2 periods while armed
    ba = 1'b0;
    push_both(16'hC000, 8'h55);
    push_b(16'h002D, 8'h01);
    push_b(16'h002E, 8'hC0);
    done_exp_a++;
    done_exp_b++;
    send_byte(8'h00, 1'b0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'h55, 1'b1);
    w0a = wr_cnt_a;
    w0b = wr_cnt_b;
    repeat (24) @(posedge clk);
    #1;
    check("ba_nowr_a", wr_cnt_a, w0a);
    check("ba_nowr_b", wr_cnt_b, w0b);
    check("ba_dma_held_a", ifa.dma, 1);
    check("ba_dma_held_b", ifb.dma, 1);
    ba = 1'b1;
    finish_load("ba");

    // Address wrap FFFF -> 0000
    push_both(16'hFFFF, 8'h11);
    push_both(16'h0000, 8'h22);
    push_b(16'h002D, 8'h01);
    push_b(16'h002E, 8'h00);
    done_exp_a++;
    done_exp_b++;
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    finish_load("wrap");

    // Stream ends inside the header
    dma_seen_a = 1'b0;
    dma_seen_b = 1'b0;
    w0a = wr_cnt_a;
    w0b = wr_cnt_b;
    send_byte(8'h00, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("err_a", ifa.err, 1);
    check("err_b", ifb.err, 1);
    check("err_busy", ifb.busy, 0);
    check("err_no_dma_a", dma_seen_a, 0);
    check("err_no_dma_b", dma_seen_b, 0);
    check("err_no_wr_a", wr_cnt_a, w0a);
    check("err_no_wr_b", wr_cnt_b, w0b);

    // Normal load with err still set
    push_both(16'h2010, 8'h7E);
    push_b(16'h002D, 8'h11);
    push_b(16'h002E, 8'h20);
    done_exp_a++;
    done_exp_b++;
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h7E, 1'b1);
    finish_load("after_err");
    check("err_sticky_b", ifb.err, 1);

    // Reset during a bus write
    push_both(16'h4000, 8'hAA);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'hAA, 1'b0);
    t = 0;
    while (ifb.rw !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midwr_rw_low", ifb.rw, 0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midwr_rw_a", ifa.rw, 1);
    check("midwr_rw_b", ifb.rw, 1);
    check("midwr_dma_a", ifa.dma, 0);
    check("midwr_dma_b", ifb.dma, 0);
    check("midwr_busy_b", ifb.busy, 0);
    check("midwr_err_cleared", ifb.err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    w0a = wr_cnt_a;
    w0b = wr_cnt_b;
    repeat (60) @(posedge clk);
    #1;
    check("midwr_no_more_wr_a", wr_cnt_a, w0a);
    check("midwr_no_more_wr_b", wr_cnt_b, w0b);
    check("midwr_left_a", exp_a.size(), 0);
    check("midwr_left_b", exp_b.size(), 0);
    check("midwr_idle_dma", ifb.dma, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
